// File: rtl/lower_level_memory.sv
// Word-wide backing store under the L1 with a fixed access latency.
// Four-phase request handshake; saturating read/write traffic counters.
module lower_level_memory #(
  parameter int ADDR_BITS = 10,
  parameter int LATENCY   = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] addrFromL1,
  input  logic        enableFromL1,
  input  logic        writeFromL1,
  input  logic [31:0] dataFromL1,
  output logic [31:0] dataToL1,
  output logic        readyToL1,
  output logic        busy,
  output logic [31:0] readCount,
  output logic [31:0] writeCount
);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    RESP,
    WAIT_LOW
  } state_t;

  localparam logic [7:0] CNT_INIT = 8'(LATENCY - 1);

  state_t               state;
  state_t               nextState;
  logic [7:0]           cnt;
  logic [ADDR_BITS-1:0] idxReg;
  logic                 wrReg;
  logic [31:0]          dataReg;
  logic [31:0]          mem [2**ADDR_BITS];

  logic                 accept;
  logic                 enterResp;
  logic [ADDR_BITS-1:0] curIdx;
  logic                 curWr;
  logic [31:0]          curData;
  logic                 unusedAddr;

  assign unusedAddr = ^{addrFromL1[31:ADDR_BITS+2],
                        addrFromL1[1:0]};

  assign readyToL1 = (state == RESP);
  assign busy      = (state != IDLE);

  // With LATENCY = 1 the RESP edge is the accept edge, so use live inputs.
  assign curIdx  = (state == IDLE) ? addrFromL1[ADDR_BITS+1:2] : idxReg;
  assign curWr   = (state == IDLE) ? writeFromL1 : wrReg;
  assign curData = (state == IDLE) ? dataFromL1 : dataReg;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= nextState;
    end
  end

  always_comb begin
    nextState = state;
    accept    = 1'b0;
    enterResp = 1'b0;
    unique case (state)
      IDLE: begin
        if (enableFromL1) begin
          accept = 1'b1;
          if (LATENCY == 1) begin
            nextState = RESP;
            enterResp = 1'b1;
          end else begin
            nextState = BUSY;
          end
        end
      end
      BUSY: begin
        if (cnt == 8'd1) begin
          nextState = RESP;
          enterResp = 1'b1;
        end
      end
      RESP: nextState = WAIT_LOW;
      WAIT_LOW: begin
        if (!enableFromL1) nextState = IDLE;
      end
      default: nextState = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt        <= '0;
      idxReg     <= '0;
      wrReg      <= 1'b0;
      dataReg    <= '0;
      dataToL1   <= '0;
      readCount  <= '0;
      writeCount <= '0;
    end else begin
      if (accept) begin
        cnt     <= CNT_INIT;
        idxReg  <= addrFromL1[ADDR_BITS+1:2];
        wrReg   <= writeFromL1;
        dataReg <= dataFromL1;
      end else if (state == BUSY) begin
        cnt <= cnt - 8'd1;
      end
      if (enterResp) begin
        dataToL1 <= curWr ? curData : mem[curIdx];
      end
      if (state == RESP) begin
        if (wrReg) begin
          if (writeCount != '1) writeCount <= writeCount + 32'd1;
        end else begin
          if (readCount != '1) readCount <= readCount + 32'd1;
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    if (enterResp && curWr) begin
      mem[curIdx] <= curData;
    end
  end

endmodule

// File: tb/tb_lower_level_memory.sv
// Scoreboarded bench: a LATENCY=4 and a LATENCY=1 instance checked
// against a word-array model with saturating counters.
module tb_lower_level_memory;

  typedef struct {
    logic [31:0] data;
    int          cyc;
  } exp_t;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] addr [2];
  logic        en   [2];
  logic        wr   [2];
  logic [31:0] wd   [2];
  logic [31:0] rd   [2];
  logic        rdy  [2];
  logic        bsy  [2];
  logic [31:0] rcnt [2];
  logic [31:0] wcnt [2];

  logic [31:0] mm [2][1024];
  logic [31:0] rcM [2];
  logic [31:0] wcM [2];
  exp_t        q0 [$];
  exp_t        q1 [$];
  int          cyc = 0;
  int          vec = 0;
  int          fail = 0;

  lower_level_memory #(.ADDR_BITS(10), .LATENCY(4)) dutA (
    .clock(clock), .reset(reset),
    .addrFromL1(addr[0]), .enableFromL1(en[0]),
    .writeFromL1(wr[0]), .dataFromL1(wd[0]),
    .dataToL1(rd[0]), .readyToL1(rdy[0]), .busy(bsy[0]),
    .readCount(rcnt[0]), .writeCount(wcnt[0])
  );

  lower_level_memory #(.ADDR_BITS(10), .LATENCY(1)) dutB (
    .clock(clock), .reset(reset),
    .addrFromL1(addr[1]), .enableFromL1(en[1]),
    .writeFromL1(wr[1]), .dataFromL1(wd[1]),
    .dataToL1(rd[1]), .readyToL1(rdy[1]), .busy(bsy[1]),
    .readCount(rcnt[1]), .writeCount(wcnt[1])
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    vec++;
    if (act !== exp) begin
      fail++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] sat(input logic [31:0] v);
    return (v == 32'hFFFFFFFF) ? v : v + 32'd1;
  endfunction

  // Monitor: every ready pulse must match the oldest pending expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clock);
      for (int d = 0; d < 2; d++) begin
        if (rdy[d]) begin
          if ((d == 0 && q0.size() == 0) || (d == 1 && q1.size() == 0)) begin
            vec++;
            fail++;
            $display("FAIL unexpectedReady dut%0d at cycle %0d", d, cyc);
          end else begin
            e = (d == 0) ? q0.pop_front() : q1.pop_front();
            chk($sformatf("data dut%0d", d), rd[d], e.data);
            chk($sformatf("readyCycle dut%0d", d), 32'(cyc), 32'(e.cyc));
          end
        end
      end
    end
  end

  task automatic xact(input int d, input logic w, input logic [31:0] a,
                      input logic [31:0] dat, input int hold);
    exp_t e;
    int   n;
    int   lat;
    lat = (d == 0) ? 4 : 1;
    @(negedge clock);
    en[d]   = 1'b1;
    wr[d]   = w;
    addr[d] = a;
    wd[d]   = dat;
    e.data  = w ? dat : mm[d][a[11:2]];
    if (w) mm[d][a[11:2]] = dat;
    e.cyc = cyc + lat;
    if (d == 0) q0.push_back(e);
    else q1.push_back(e);
    n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (!rdy[d] && n < 300);
    if (!rdy[d]) begin
      vec++;
      fail++;
      $display("FAIL readyTimeout dut%0d: got none, want pulse", d);
    end
    repeat (hold) begin
      @(negedge clock);
      chk("busyWhileHeld", 32'(bsy[d]), 32'd1);
    end
    en[d] = 1'b0;
    repeat (2) @(negedge clock);
    if (w) wcM[d] = sat(wcM[d]);
    else rcM[d] = sat(rcM[d]);
    chk($sformatf("busyIdle dut%0d", d), 32'(bsy[d]), 32'd0);
    chk($sformatf("readCount dut%0d", d), rcnt[d], rcM[d]);
    chk($sformatf("writeCount dut%0d", d), wcnt[d], wcM[d]);
  endtask

  task automatic chkReset();
    for (int d = 0; d < 2; d++) begin
      chk("rstReady", 32'(rdy[d]), 32'd0);
      chk("rstBusy", 32'(bsy[d]), 32'd0);
      chk("rstData", rd[d], 32'd0);
      chk("rstReadCount", rcnt[d], 32'd0);
      chk("rstWriteCount", wcnt[d], 32'd0);
    end
  endtask

  initial begin
    logic [31:0] a;
    for (int d = 0; d < 2; d++) begin
      en[d] = 1'b0; wr[d] = 1'b0; addr[d] = '0; wd[d] = '0;
      rcM[d] = '0; wcM[d] = '0;
      for (int i = 0; i < 1024; i++) mm[d][i] = '0;
    end
    repeat (3) begin
      @(negedge clock);
      chkReset();
    end
    reset = 1'b1;
    @(negedge clock);
    chkReset();

    xact(0, 1'b1, 32'h2550b24f, 32'hDEADBEEF, 0);
    xact(0, 1'b0, 32'h2550b24f, 32'h0, 0);
    xact(0, 1'b0, 32'h2550b24c, 32'h0, 5);

    @(negedge clock);
    en[0] = 1'b1; wr[0] = 1'b1;
    addr[0] = 32'h49181e26; wd[0] = 32'h12345678;
    @(posedge clock);
    @(posedge clock);
    @(posedge clock);
    #1;
    reset = 1'b0;
    en[0] = 1'b0;
    @(negedge clock);
    chkReset();
    reset = 1'b1;
    rcM[0] = '0; wcM[0] = '0; rcM[1] = '0; wcM[1] = '0;
    xact(0, 1'b0, 32'h49181e26, 32'h0, 0);

    xact(1, 1'b0, 32'h00000000, 32'h0, 0);
    xact(1, 1'b0, 32'h00000004, 32'h0, 0);
    xact(1, 1'b1, 32'h00000008, 32'hCAFEF00D, 0);
    @(negedge clock);
    dutB.readCount = 32'hFFFFFFFE;
    rcM[1] = 32'hFFFFFFFE;
    repeat (3) xact(1, 1'b0, 32'h00000008, 32'h0, 0);
    chk("saturatedRead", rcnt[1], 32'hFFFFFFFF);

    for (int i = 0; i < 40; i++) begin
      a = $urandom() & 32'hFFFFF03F;
      xact(i % 2, 1'($urandom_range(0, 1)), a, $urandom(),
           int'($urandom_range(0, 3)));
    end

    repeat (3) @(negedge clock);
    if (q0.size() != 0 || q1.size() != 0) begin
      vec++;
      fail++;
      $display("FAIL pendingResponses: got %0d left, want 0",
               q0.size() + q1.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vec, fail);
    $finish;
  end

endmodule
